// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multicycle control unit: main FSM, ALU decode, ImmSrc decode
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       IllegalInstr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRPC   = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  state_t state_q, state_d;

  logic       pc_update, branch, ir_write, mem_write, reg_write;
  logic [1:0] alu_op;

  logic is_lw, is_sw, is_r, is_i, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic alu_f3_ok, br_f3_ok, legal;

  assign is_lw    = (op == 7'b0000011);
  assign is_sw    = (op == 7'b0100011);
  assign is_r     = (op == 7'b0110011);
  assign is_i     = (op == 7'b0010011);
  assign is_br    = (op == 7'b1100011);
  assign is_jal   = (op == 7'b1101111);
  assign is_jalr  = (op == 7'b1100111);
  assign is_lui   = (op == 7'b0110111);
  assign is_auipc = (op == 7'b0010111);

  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign legal     = is_lw || is_sw || is_jal || is_jalr || is_lui || is_auipc ||
                     ((is_r || is_i) && alu_f3_ok) || (is_br && br_f3_ok);

  // State register; reset lands in FETCH regardless of where the FSM was
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= state_t'(RESET_STATE);
    else        state_q <= state_d;
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d      = S_FETCH;
    pc_update    = 1'b0;
    branch       = 1'b0;
    ir_write     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    alu_op       = 2'b00;
    IllegalInstr = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (!legal) begin
          IllegalInstr = 1'b1;
          state_d      = S_FETCH;
        end else if (is_lw || is_sw) state_d = S_MEMADR;
        else if (is_r)               state_d = S_EXECUTER;
        else if (is_i)               state_d = S_EXECUTEI;
        else if (is_br)              state_d = S_BRANCH;
        else if (is_jal)             state_d = S_JAL;
        else if (is_jalr)            state_d = S_JALR;
        else if (is_lui)             state_d = S_LUI;
        else                         state_d = S_ALUWB;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = is_lw ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      S_JAL, S_JALRPC: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALRPC;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are held off combinationally while reset is asserted
  assign PCWrite  = rst_n & (pc_update | (branch & (Zero ^ funct3[0])));
  assign IRWrite  = rst_n & ir_write;
  assign MemWrite = rst_n & mem_write;
  assign RegWrite = rst_n & reg_write;

  // ALU operation select from ALUOp and instruction fields
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 3'b000;
    if (is_sw)                 ImmSrc = 3'b001;
    else if (is_br)            ImmSrc = 3'b010;
    else if (is_jal)           ImmSrc = 3'b011;
    else if (is_lui || is_auipc) ImmSrc = 3'b100;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUControl;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .IllegalInstr(IllegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5,
                         ER = 4'd6, EI = 4'd7, WB = 4'd8, BR = 4'd9, JL = 4'd10,
                         JR = 4'd11, JRPC = 4'd12, LU = 4'd13;

  typedef struct packed {
    logic [6:0]      op;
    logic [2:0]      f3;
    logic            f7;
    logic            z;
    logic [2:0]      len;
    logic [4:0][3:0] seq;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  logic [17:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic [6:0] o, logic [2:0] f, logic f7, logic z, logic [2:0] n,
                              logic [3:0] s0, logic [3:0] s1, logic [3:0] s2,
                              logic [3:0] s3, logic [3:0] s4);
    vec_t v;
    v.op = o; v.f3 = f; v.f7 = f7; v.z = z; v.len = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    return v;
  endfunction

  // Reference model: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,RegWrite,ImmSrc,ALUControl,Illegal}
  function automatic logic [17:0] model(logic [3:0] s, logic [6:0] o, logic [2:0] f, logic f7, logic z);
    logic pcw, adr, mw, irw, rw, ill, legal;
    logic [1:0] rs, sa, sb, aop;
    logic [2:0] imm, alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
    case (o)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      7'b0110111, 7'b0010111: imm = 3'b100;
      default: imm = 3'b000;
    endcase
    case (o)
      7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: legal = 1;
      7'b0110011, 7'b0010011: legal = (f == 3'b000 || f == 3'b010 || f == 3'b110 || f == 3'b111);
      7'b1100011: legal = (f == 3'b000 || f == 3'b001);
      default: legal = 0;
    endcase
    case (s)
      F:    begin irw = 1; sb = 2'b10; rs = 2'b10; pcw = 1; end
      D:    begin sa = 2'b01; sb = 2'b01; ill = ~legal; end
      MA:   begin sa = 2'b10; sb = 2'b01; end
      MR:   adr = 1;
      MWB:  begin rs = 2'b01; rw = 1; end
      MW:   begin adr = 1; mw = 1; end
      ER:   begin sa = 2'b10; aop = 2'b10; end
      EI:   begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      WB:   rw = 1;
      BR:   begin sa = 2'b10; aop = 2'b01; pcw = z ^ f[0]; end
      JL, JRPC: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      JR:   begin sa = 2'b10; sb = 2'b01; end
      LU:   begin sa = 2'b11; sb = 2'b01; end
      default: ;
    endcase
    if (aop == 2'b01) alu = 3'b001;
    else if (aop == 2'b10) begin
      case (f)
        3'b000: alu = (o[5] && f7) ? 3'b001 : 3'b000;
        3'b010: alu = 3'b101;
        3'b110: alu = 3'b011;
        3'b111: alu = 3'b010;
        default: alu = 3'b000;
      endcase
    end else alu = 3'b000;
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu, ill};
  endfunction

  function automatic logic [17:0] actual();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite,
            ImmSrc, ALUControl, IllegalInstr};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // Pop one expected record and compare with the current outputs
  task automatic pop_check(input string name);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, actual(), e);
    end
  endtask

  // Reset-time outputs: FETCH decode with all enables gated off
  function automatic logic [17:0] reset_exp(logic [6:0] o, logic [2:0] f, logic f7, logic z);
    logic [17:0] e;
    e = model(F, o, f, f7, z);
    e[17] = 0; e[15] = 0; e[14] = 0; e[7] = 0;
    return e;
  endfunction

  initial begin
    vecs[0]  = mk(7'b0000011, 3'b010, 0, 0, 5, F, D, MA, MR, MWB);
    vecs[1]  = mk(7'b0100011, 3'b010, 0, 1, 4, F, D, MA, MW, F);
    vecs[2]  = mk(7'b0110011, 3'b000, 1, 0, 4, F, D, ER, WB, F);
    vecs[3]  = mk(7'b0010011, 3'b000, 1, 0, 4, F, D, EI, WB, F);
    vecs[4]  = mk(7'b0110011, 3'b110, 0, 0, 4, F, D, ER, WB, F);
    vecs[5]  = mk(7'b0010011, 3'b010, 0, 0, 4, F, D, EI, WB, F);
    vecs[6]  = mk(7'b0010011, 3'b111, 0, 1, 4, F, D, EI, WB, F);
    vecs[7]  = mk(7'b1100011, 3'b000, 0, 1, 3, F, D, BR, F, F);
    vecs[8]  = mk(7'b1100011, 3'b000, 0, 0, 3, F, D, BR, F, F);
    vecs[9]  = mk(7'b1100011, 3'b001, 0, 0, 3, F, D, BR, F, F);
    vecs[10] = mk(7'b1100011, 3'b001, 0, 1, 3, F, D, BR, F, F);
    vecs[11] = mk(7'b1101111, 3'b000, 0, 1, 4, F, D, JL, WB, F);
    vecs[12] = mk(7'b1100111, 3'b000, 0, 0, 5, F, D, JR, JRPC, WB);
    vecs[13] = mk(7'b0110111, 3'b000, 0, 0, 4, F, D, LU, WB, F);
    vecs[14] = mk(7'b0000000, 3'b000, 0, 0, 2, F, D, F, F, F);
    vecs[15] = mk(7'b0110011, 3'b001, 0, 0, 2, F, D, F, F, F);
    vecs[16] = mk(7'b1100011, 3'b100, 0, 0, 2, F, D, F, F, F);

    rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    #12;
    check("reset_outputs", actual(), reset_exp(op, funct3, funct7b5, Zero));
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      op = vecs[v].op; funct3 = vecs[v].f3; funct7b5 = vecs[v].f7; Zero = vecs[v].z;
      for (int c = 0; c < int'(vecs[v].len); c++)
        exp_q.push_back(model(vecs[v].seq[c], op, funct3, funct7b5, Zero));
      for (int c = 0; c < int'(vecs[v].len); c++) begin
        #1;
        pop_check($sformatf("vec%0d_cycle%0d", v, c));
        @(negedge clk);
      end
    end

    // Reset asserted during MEMWRITE of a store
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    exp_q.push_back(model(F, op, funct3, funct7b5, Zero));
    exp_q.push_back(model(D, op, funct3, funct7b5, Zero));
    exp_q.push_back(model(MA, op, funct3, funct7b5, Zero));
    exp_q.push_back(model(MW, op, funct3, funct7b5, Zero));
    for (int c = 0; c < 4; c++) begin
      #1;
      pop_check($sformatf("sw_rst_cycle%0d", c));
      if (c < 3) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("memwrite_drop_on_reset", actual(), reset_exp(op, funct3, funct7b5, Zero));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(F, op, funct3, funct7b5, Zero));
    exp_q.push_back(model(D, op, funct3, funct7b5, Zero));
    #1;
    pop_check("after_reset_fetch");
    @(negedge clk);
    #1;
    pop_check("after_reset_decode");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
